// File: rtl/controlador_barrido_pkg.sv
// Shared types and digit-selection helpers for the display scan sequencer.
package barrido_pkg;

  localparam int unsigned NUM_DIGITOS = 4;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    APAGADO   = 2'd1,
    ENCENDIDO = 2'd2
  } estado_t;

  // First enabled digit strictly after s, wrapping back to s itself.
  function automatic logic [1:0] siguiente_digito(input logic [1:0] s,
                                                  input logic [NUM_DIGITOS-1:0] m);
    logic [1:0] r;
    logic [1:0] k;
    r = s;
    for (int i = NUM_DIGITOS; i >= 1; i--) begin
      k = s + 2'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  // First enabled digit starting at s itself.
  function automatic logic [1:0] primer_digito(input logic [1:0] s,
                                               input logic [NUM_DIGITOS-1:0] m);
    logic [1:0] r;
    logic [1:0] k;
    r = s;
    for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
      k = s + 2'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  function automatic logic [NUM_DIGITOS-1:0] anodo_de(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/controlador_barrido_if.sv
// Scan control bus: enable/mask towards the sequencer, select/anodes/advance back.
interface barrido_if;
  import barrido_pkg::*;

  logic                   habilitar_i;
  logic [NUM_DIGITOS-1:0] mascara_i;
  logic [1:0]             seleccion_o;
  logic [NUM_DIGITOS-1:0] anodo_o;
  logic                   avance_o;

  modport master (output habilitar_i, mascara_i,
                  input  seleccion_o, anodo_o, avance_o);
  modport slave  (input  habilitar_i, mascara_i,
                  output seleccion_o, anodo_o, avance_o);
endinterface

// File: rtl/controlador_barrido_contador.sv
// Period counter shared by the timed states; terminal flag compares against a muxed limit.
module contador_periodo #(
  parameter int unsigned ANCHO = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ANCHO-1:0] limite_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             fin_c
);

  logic [ANCHO-1:0] cuenta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cuenta_q <= '0;
    else if (clr_i) cuenta_q <= '0;
    else if (en_i)  cuenta_q <= cuenta_q + ANCHO'(1);
  end

  assign fin_c = (cuenta_q == limite_i);

endmodule

// File: rtl/controlador_barrido.sv
// Four-digit display scan sequencer: mux select, active-low anodes, advance pulse.
// Optional blanking gap between digits enabled by defining BARRIDO_APAGADO_EN.
module controlador_barrido
  import barrido_pkg::*;
#(
  parameter int unsigned CICLOS_DIGITO  = 100_000,
  parameter int unsigned CICLOS_APAGADO = 1_000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  barrido_if.slave  bus
);

  localparam int unsigned MAX_CICLOS = (CICLOS_DIGITO > CICLOS_APAGADO) ?
                                       CICLOS_DIGITO : CICLOS_APAGADO;
  localparam int unsigned ANCHO      = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;
  localparam logic [ANCHO-1:0] LIM_DIGITO = ANCHO'(CICLOS_DIGITO - 1);

  estado_t                estado_q, estado_d;
  logic [1:0]             sel_q, sel_d;
  logic [NUM_DIGITOS-1:0] anodo_q, anodo_d;
  logic                   avance_q, avance_d;
  logic [ANCHO-1:0]       limite_c;
  logic                   fin_c;
  logic                   activo_c;
  logic                   clr_c;
  logic                   en_c;

`ifdef BARRIDO_APAGADO_EN
  localparam logic [ANCHO-1:0] LIM_APAGADO = ANCHO'(CICLOS_APAGADO - 1);
  localparam estado_t          ENTRADA     = APAGADO;
  assign limite_c = (estado_q == APAGADO) ? LIM_APAGADO : LIM_DIGITO;
`else
  localparam estado_t          ENTRADA     = ENCENDIDO;
  assign limite_c = LIM_DIGITO;
`endif

  assign activo_c = bus.habilitar_i && (bus.mascara_i != '0);
  // Counter restarts on every state change, on terminal count and while idle.
  assign clr_c    = !activo_c || (estado_q == REPOSO) || fin_c;
  assign en_c     = (estado_q != REPOSO);

  contador_periodo #(.ANCHO(ANCHO)) u_contador (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .limite_i (limite_c),
    .clr_i    (clr_c),
    .en_i     (en_c),
    .fin_c    (fin_c)
  );

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q <= REPOSO;
      sel_q    <= 2'b00;
      anodo_q  <= '1;
      avance_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      anodo_q  <= anodo_d;
      avance_q <= avance_d;
    end
  end

  // Next-state logic; losing enable or mask always returns to idle.
  always_comb begin
    estado_d = estado_q;
    if (!activo_c) begin
      estado_d = REPOSO;
    end else begin
      case (estado_q)
        REPOSO:    estado_d = ENTRADA;
`ifdef BARRIDO_APAGADO_EN
        APAGADO:   if (fin_c) estado_d = ENCENDIDO;
`endif
        ENCENDIDO: if (fin_c) estado_d = ENTRADA;
        default:   estado_d = REPOSO;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    sel_d    = sel_q;
    avance_d = 1'b0;
    if (activo_c) begin
      case (estado_q)
        REPOSO: begin
          sel_d    = primer_digito(sel_q, bus.mascara_i);
          avance_d = 1'b1;
        end
        ENCENDIDO: begin
          if (fin_c) begin
            sel_d    = siguiente_digito(sel_q, bus.mascara_i);
            avance_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A digit whose mask bit drops mid-period is blanked immediately.
    anodo_d = '1;
    if ((estado_d == ENCENDIDO) && bus.mascara_i[sel_d]) anodo_d = anodo_de(sel_d);
  end

  assign bus.seleccion_o = sel_q;
  assign bus.anodo_o     = anodo_q;
  assign bus.avance_o    = avance_q;

endmodule

// File: tb/tb_controlador_barrido.sv
// Directed bench for controlador_barrido (CICLOS_DIGITO=4, CICLOS_APAGADO=2), with or without blanking.
module tb_controlador_barrido;

  localparam int D = 4;
`ifdef BARRIDO_APAGADO_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif
  localparam int P = G + D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errores = 0;
  int   total   = 0;

  barrido_if bus();

  controlador_barrido #(.CICLOS_DIGITO(D), .CICLOS_APAGADO(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hab;
    logic [3:0] mask;
    int         n;
    logic [1:0] sel;
    logic [3:0] an;
    logic       av;
  } vec_t;

  vec_t tabla[$];

  // Expected anode value at a period start: blank with the gap, lit otherwise.
  function automatic logic [3:0] inicio(input logic [3:0] lit);
    return (G > 0) ? 4'hF : lit;
  endfunction

  task automatic add(input logic h, input logic [3:0] m, input int n,
                     input logic [1:0] s, input logic [3:0] a, input logic v);
    vec_t e;
    e.hab = h; e.mask = m; e.n = n; e.sel = s; e.an = a; e.av = v;
    tabla.push_back(e);
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nombre, input logic [1:0] s,
                     input logic [3:0] a, input logic v);
    total++;
    if (bus.seleccion_o !== s || bus.anodo_o !== a || bus.avance_o !== v) begin
      errores++;
      $display("FAIL %s: got sel=%0d anodo=%b avance=%b, want sel=%0d anodo=%b avance=%b",
               nombre, bus.seleccion_o, bus.anodo_o, bus.avance_o, s, a, v);
    end
  endtask

  task automatic chk_int(input string nombre, input int got, input int want);
    total++;
    if (got != want) begin
      errores++;
      $display("FAIL %s: got %0d, want %0d", nombre, got, want);
    end
  endtask

  initial begin
    logic av0;
    int   n;
    int   lit;
    int   viol;
    bit   visto;

    av0 = 1'(G == 0);
    bus.habilitar_i = 1'b0;
    bus.mascara_i   = 4'h0;

    // Reset held over several edges
    paso(); paso();
    chk("reset_held", 2'd0, 4'hF, 1'b0);
    rst = 1'b0;

    // Full rotation
    add(0, 4'hF, 3,       2'd0, 4'hF,         0);
    add(1, 4'hF, 1,       2'd0, inicio(4'hE), 1);
    add(1, 4'hF, G,       2'd0, 4'hE,         av0);
    add(1, 4'hF, D-1,     2'd0, 4'hE,         0);
    add(1, 4'hF, 1,       2'd1, inicio(4'hD), 1);
    add(1, 4'hF, G+D-1,   2'd1, 4'hD,         0);
    add(1, 4'hF, 1,       2'd2, inicio(4'hB), 1);
    add(1, 4'hF, P,       2'd3, inicio(4'h7), 1);
    add(1, 4'hF, P,       2'd0, inicio(4'hE), 1);
    // Partial mask 1010
    add(0, 4'hF, 1,       2'd0, 4'hF,         0);
    add(1, 4'hA, 1,       2'd1, inicio(4'hD), 1);
    add(1, 4'hA, P,       2'd3, inicio(4'h7), 1);
    add(1, 4'hA, P,       2'd1, inicio(4'hD), 1);
    add(1, 4'hA, G,       2'd1, 4'hD,         av0);
    // Single digit 0100
    add(0, 4'h4, 1,       2'd1, 4'hF,         0);
    add(1, 4'h4, 1,       2'd2, inicio(4'hB), 1);
    add(1, 4'h4, P,       2'd2, inicio(4'hB), 1);
    add(1, 4'h4, G,       2'd2, 4'hB,         av0);
    add(1, 4'h4, D-1,     2'd2, 4'hB,         0);
    add(1, 4'h4, 1,       2'd2, inicio(4'hB), 1);
    // Disable mid-digit, then re-enable
    add(1, 4'h4, G+1,     2'd2, 4'hB,         0);
    add(0, 4'h4, 1,       2'd2, 4'hF,         0);
    add(1, 4'h4, 1,       2'd2, inicio(4'hB), 1);
    add(1, 4'h4, G,       2'd2, 4'hB,         av0);
    add(1, 4'h4, D-1,     2'd2, 4'hB,         0);
    add(1, 4'h4, 1,       2'd2, inicio(4'hB), 1);
    // Current digit masked out mid-lit, rotation at normal terminal count
    add(0, 4'hF, 1,       2'd2, 4'hF,         0);
    add(1, 4'hF, 1,       2'd2, inicio(4'hB), 1);
    add(1, 4'hF, G,       2'd2, 4'hB,         av0);
    add(1, 4'hB, 1,       2'd2, 4'hF,         0);
    add(1, 4'hB, D-2,     2'd2, 4'hF,         0);
    add(1, 4'hB, 1,       2'd3, inicio(4'h7), 1);
    add(1, 4'hB, G+D-1,   2'd3, 4'h7,         0);
    // Disable on the terminal-count cycle: no advance
    add(0, 4'hB, 1,       2'd3, 4'hF,         0);

    foreach (tabla[i]) begin
      bus.habilitar_i = tabla[i].hab;
      bus.mascara_i   = tabla[i].mask;
      repeat (tabla[i].n) paso();
      chk($sformatf("vec%0d", i), tabla[i].sel, tabla[i].an, tabla[i].av);
    end

    // Advance interval and lit cycles per period
    bus.habilitar_i = 1'b1;
    bus.mascara_i   = 4'hF;
    n = 0;
    visto = 1'b0;
    while (!visto && n < 50) begin
      paso(); n++;
      visto = bus.avance_o;
    end
    chk_int("first_avance_seen", int'(visto), 1);
    n = 0; lit = 0; visto = 1'b0;
    while (!visto && n < 50) begin
      paso(); n++;
      if (bus.anodo_o != 4'hF) lit++;
      visto = bus.avance_o;
    end
    chk_int("avance_interval", n, P);
    chk_int("lit_cycles", lit, D);

    // Partial mask never lights digits 0 or 2
    bus.mascara_i = 4'hA;
    viol = 0;
    for (int c = 0; c < 3 * P; c++) begin
      paso();
      if (bus.anodo_o == 4'hE || bus.anodo_o == 4'hB) viol++;
    end
    chk_int("mask_1010_no_forbidden", viol, 0);
    chk_int("mask_1010_sel_odd", int'(bus.seleccion_o[0]), 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", 2'd0, 4'hF, 1'b0);
    bus.habilitar_i = 1'b0;
    paso(); paso(); paso();
    chk("reset_hold", 2'd0, 4'hF, 1'b0);
    rst = 1'b0;
    paso();
    chk("idle_after_reset", 2'd0, 4'hF, 1'b0);
    bus.habilitar_i = 1'b1;
    bus.mascara_i   = 4'hF;
    paso();
    chk("resume_from_idle", 2'd0, inicio(4'hE), 1'b1);
    repeat (G + D) paso();
    chk("resume_next_digit", 2'd1, inicio(4'hD), 1'b1);

    $display("Result: errors=%0d of %0d checks", errores, total);
    $finish;
  end

endmodule
